// File: rtl/pio_instr_receiver.sv
// pio_instr_receiver: FPGA-side endpoint of the HPS instruction PIO channel.
// Detects the rising edge of the HPS strobe, latches the 29-bit instruction,
// and executes it as a single image-memory write, a single image-memory read,
// or a command dispatched to the processing core. Status goes back on
// pio_flags and read data on pio_rdata.
//
// Ports:
//   clk_clk, reset_reset_n         clock, asynchronous active-low reset
//   pio_enable, pio_instruct       HPS strobe (level) and instruction word
//                                  [2:0] op, [19:3] addr, [27:20] data, [28] rsvd
//   pio_flags                      [0] done, [1] busy, [2] error, [3] timeout
//   pio_rdata                      result of the last completed READ
//   mem_addr/mem_wdata/mem_we/mem_re/mem_rdata   image memory port
//   cmd_valid/cmd_ready/cmd_op/cmd_param/cmd_done processing-core command port
module pio_instr_receiver #(
  parameter int unsigned ADDR_W         = 17,
  parameter int unsigned DATA_W         = 8,
  parameter int unsigned MEM_DEPTH      = 76800,
  parameter int unsigned RD_LATENCY     = 2,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              pio_enable,
  input  logic [28:0]       pio_instruct,
  output logic [3:0]        pio_flags,
  output logic [DATA_W-1:0] pio_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cmd_valid,
  input  logic              cmd_ready,
  output logic [2:0]        cmd_op,
  output logic [DATA_W-1:0] cmd_param,
  input  logic              cmd_done
);

  localparam int unsigned INSTR_W   = 29;
  localparam int unsigned OP_W      = 3;
  localparam int unsigned F_ADDR_W  = 17;
  localparam int unsigned F_DATA_W  = 8;
  localparam int unsigned CNT_W     = 16;

  localparam logic [OP_W-1:0] OP_NOP   = 3'd0;
  localparam logic [OP_W-1:0] OP_WRITE = 3'd1;
  localparam logic [OP_W-1:0] OP_READ  = 3'd2;
  localparam logic [OP_W-1:0] OP_BAD   = 3'd7;

  // S_RESP is a one-cycle completion stage shared by every path, so that the
  // status flags are published one clock after the FSM reaches S_DONE.
  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_DECODE = 3'd1,
    S_WR     = 3'd2,
    S_RD     = 3'd3,
    S_EXEC   = 3'd4,
    S_RESP   = 3'd5,
    S_DONE   = 3'd6
  } state_t;

  state_t state_q, state_d;

  logic                enable_q;
  logic [INSTR_W-1:0]  instr_q, instr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                acc_q, acc_d;
  logic                err_pend_q, err_pend_d;
  logic                to_pend_q, to_pend_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;
  logic                error_q, error_d;
  logic                timeout_q, timeout_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic                we_q, we_d;
  logic                re_q, re_d;
  logic                cvalid_q, cvalid_d;
  logic [OP_W-1:0]     cop_q, cop_d;
  logic [DATA_W-1:0]   cparam_q, cparam_d;

  // Instruction fields of the latched word.
  logic [OP_W-1:0]     op_c;
  logic [F_ADDR_W-1:0] iaddr_c;
  logic [F_DATA_W-1:0] idata_c;
  logic                resv_c;

  assign op_c    = instr_q[2:0];
  assign iaddr_c = instr_q[19:3];
  assign idata_c = instr_q[27:20];
  assign resv_c  = instr_q[28];

  logic accept_c;
  logic hs_c;
  logic exec_done_c;
  logic exec_to_c;
  logic dec_err_c;

  assign accept_c    = (state_q == S_IDLE) && pio_enable && !enable_q;
  assign hs_c        = cvalid_q && cmd_ready;
  // cmd_done only counts once the command was accepted (possibly this cycle).
  assign exec_done_c = cmd_done && (acc_q || hs_c);
  assign exec_to_c   = (state_q == S_EXEC) && !exec_done_c &&
                       (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  assign dec_err_c   = resv_c || (op_c == OP_BAD) ||
                       (((op_c == OP_WRITE) || (op_c == OP_READ)) &&
                        (32'(iaddr_c) >= MEM_DEPTH));

  // State and all registered outputs.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= S_IDLE;
      enable_q   <= 1'b0;
      instr_q    <= '0;
      cnt_q      <= '0;
      acc_q      <= 1'b0;
      err_pend_q <= 1'b0;
      to_pend_q  <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      error_q    <= 1'b0;
      timeout_q  <= 1'b0;
      rdata_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      we_q       <= 1'b0;
      re_q       <= 1'b0;
      cvalid_q   <= 1'b0;
      cop_q      <= '0;
      cparam_q   <= '0;
    end else begin
      state_q    <= state_d;
      enable_q   <= pio_enable;
      instr_q    <= instr_d;
      cnt_q      <= cnt_d;
      acc_q      <= acc_d;
      err_pend_q <= err_pend_d;
      to_pend_q  <= to_pend_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      error_q    <= error_d;
      timeout_q  <= timeout_d;
      rdata_q    <= rdata_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      we_q       <= we_d;
      re_q       <= re_d;
      cvalid_q   <= cvalid_d;
      cop_q      <= cop_d;
      cparam_q   <= cparam_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept_c) state_d = S_DECODE;
      end
      S_DECODE: begin
        if (dec_err_c) begin
          state_d = S_RESP;
        end else begin
          case (op_c)
            OP_NOP:   state_d = S_RESP;
            OP_WRITE: state_d = S_WR;
            OP_READ:  state_d = S_RD;
            default:  state_d = S_EXEC;
          endcase
        end
      end
      S_WR: state_d = S_RESP;
      S_RD: begin
        if (cnt_q == CNT_W'(RD_LATENCY)) state_d = S_RESP;
      end
      S_EXEC: begin
        if (exec_done_c || exec_to_c) state_d = S_RESP;
      end
      S_RESP: state_d = S_DONE;
      S_DONE: begin
        if (!pio_enable) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values.
  always_comb begin
    instr_d    = instr_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
    err_pend_d = err_pend_q;
    to_pend_d  = to_pend_q;
    done_d     = done_q;
    busy_d     = busy_q;
    error_d    = error_q;
    timeout_d  = timeout_q;
    rdata_d    = rdata_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    we_d       = 1'b0;
    re_d       = 1'b0;
    cop_d      = cop_q;
    cparam_d   = cparam_q;

    if (accept_c) begin
      instr_d    = pio_instruct;
      busy_d     = 1'b1;
      done_d     = 1'b0;
      error_d    = 1'b0;
      timeout_d  = 1'b0;
      err_pend_d = 1'b0;
      to_pend_d  = 1'b0;
    end

    // Counter restarts on every state change; it runs only in RD and EXEC.
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if ((state_q == S_RD) || (state_q == S_EXEC)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    if (state_q == S_DECODE) begin
      acc_d = 1'b0;
      if (dec_err_c) begin
        err_pend_d = 1'b1;
      end else if ((op_c == OP_WRITE) || (op_c == OP_READ)) begin
        addr_d  = ADDR_W'(iaddr_c);
        wdata_d = DATA_W'(idata_c);
      end
      if (state_d == S_EXEC) begin
        cop_d    = op_c;
        cparam_d = DATA_W'(idata_c);
      end
    end

    we_d = (state_d == S_WR);

    // Read strobe is issued on the second RD cycle; data is captured on the
    // RD_LATENCY-th clock after it.
    if (state_q == S_RD) begin
      re_d = (cnt_q == '0);
      if (cnt_q == CNT_W'(RD_LATENCY)) rdata_d = mem_rdata;
    end

    if (state_q == S_EXEC) begin
      acc_d = acc_q || hs_c;
      if (exec_to_c) begin
        to_pend_d  = 1'b1;
        err_pend_d = 1'b1;
      end
    end
    cvalid_d = (state_d == S_EXEC) && !acc_d;

    // Status is published together: busy falls as done and error rise.
    if (state_q == S_DONE) begin
      done_d    = 1'b1;
      busy_d    = 1'b0;
      error_d   = err_pend_q;
      timeout_d = to_pend_q;
    end
  end

  assign pio_flags = {timeout_q, error_q, busy_q, done_q};
  assign pio_rdata = rdata_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_we    = we_q;
  assign mem_re    = re_q;
  assign cmd_valid = cvalid_q;
  assign cmd_op    = cop_q;
  assign cmd_param = cparam_q;

endmodule

// File: tb/tb_pio_instr_receiver.sv
// Self-checking bench for pio_instr_receiver: directed and random
// instructions against a transaction-level model of the expected flags,
// latencies, memory traffic and core handshake.
module tb_pio_instr_receiver;

  localparam int unsigned ADDR_W = 17;
  localparam int unsigned DATA_W = 8;
  localparam int unsigned DEPTH  = 76800;
  localparam int unsigned L      = 2;
  localparam int unsigned T      = 32;

  localparam int K_ERR = 0;
  localparam int K_NOP = 1;
  localparam int K_WR  = 2;
  localparam int K_RD  = 3;
  localparam int K_EX  = 4;

  logic              clk_clk = 1'b0;
  logic              reset_reset_n;
  logic              pio_enable;
  logic [28:0]       pio_instruct;
  logic [3:0]        pio_flags;
  logic [DATA_W-1:0] pio_rdata;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata = 8'h00;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [DATA_W-1:0] cmd_param;
  logic              cmd_done;

  always #5 clk_clk = ~clk_clk;

  pio_instr_receiver #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MEM_DEPTH(DEPTH),
    .RD_LATENCY(L), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .pio_enable(pio_enable), .pio_instruct(pio_instruct),
    .pio_flags(pio_flags), .pio_rdata(pio_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_re(mem_re), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_param(cmd_param), .cmd_done(cmd_done)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0]        wmem [int];
  int                we_cnt = 0;
  int                re_cnt = 0;
  int                pend = 0;
  int                rd_addr = 0;
  logic [ADDR_W-1:0] last_we_addr = '0;
  logic [7:0]        last_we_data = '0;
  logic [7:0]        exp_rdata = 8'h00;

  function automatic logic [7:0] mem_val(input int a);
    if (wmem.exists(a)) return wmem[a];
    return 8'((a * 37 + 11) ^ (a >>> 5));
  endfunction

  // Memory: data is valid only in the clock that ends RD_LATENCY clocks after
  // the read strobe; every other cycle returns the complement.
  always @(negedge clk_clk) begin
    mem_rdata = ~mem_val(rd_addr);
    if (pend > 0) begin
      pend = pend - 1;
      if (pend == 0) mem_rdata = mem_val(rd_addr);
    end
    if (mem_re) begin
      re_cnt  = re_cnt + 1;
      rd_addr = int'(mem_addr);
      pend    = int'(L) - 1;
    end
    if (mem_we) begin
      we_cnt       = we_cnt + 1;
      last_we_addr = mem_addr;
      last_we_data = mem_wdata;
      wmem[int'(mem_addr)] = mem_wdata;
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_clk);
    #1;
  endtask

  function automatic logic [28:0] mk(input logic r, input logic [7:0] d,
                                     input logic [16:0] a, input logic [2:0] op);
    return {r, d, a, op};
  endfunction

  // Outcome of an instruction straight from the instruction-set rules.
  function automatic void model(input logic [28:0] ins, output int lat,
                                output logic [3:0] fl, output int kind);
    int op;
    int a;
    op = int'(ins[2:0]);
    a  = int'(ins[19:3]);
    if (ins[28] || op == 7 || ((op == 1 || op == 2) && a >= int'(DEPTH))) begin
      kind = K_ERR; lat = 3; fl = 4'b0101;
    end else if (op == 0) begin
      kind = K_NOP; lat = 3; fl = 4'b0001;
    end else if (op == 1) begin
      kind = K_WR; lat = 4; fl = 4'b0001;
    end else if (op == 2) begin
      kind = K_RD; lat = 4 + int'(L); fl = 4'b0001;
    end else begin
      kind = K_EX; lat = 0; fl = 4'b0001;
    end
  endfunction

  function automatic logic [63:0] all_out();
    return 64'({pio_flags, pio_rdata, mem_addr, mem_wdata, mem_we, mem_re,
                cmd_valid, cmd_op, cmd_param});
  endfunction

  task automatic strobe(input logic [28:0] ins);
    pio_instruct = ins;
    pio_enable   = 1'b1;
    tick();
  endtask

  task automatic do_simple(input logic [28:0] ins, input string tag);
    int lat;
    int kind;
    int we0;
    int re0;
    logic [3:0] fl;
    logic [7:0] rexp;
    model(ins, lat, fl, kind);
    rexp = mem_val(int'(ins[19:3]));
    we0 = we_cnt;
    re0 = re_cnt;
    strobe(ins);
    chk({tag, " busy"}, 64'(pio_flags), 64'(4'b0010));
    pio_instruct = 29'($urandom);
    repeat (lat - 1) tick();
    chk({tag, " pre-done"}, 64'(pio_flags), 64'(4'b0010));
    tick();
    chk({tag, " flags"}, 64'(pio_flags), 64'(fl));
    chk({tag, " we count"}, 64'(we_cnt - we0), 64'(kind == K_WR));
    chk({tag, " re count"}, 64'(re_cnt - re0), 64'(kind == K_RD));
    if (kind == K_WR) begin
      chk({tag, " we addr"}, 64'(last_we_addr), 64'(ins[19:3]));
      chk({tag, " we data"}, 64'(last_we_data), 64'(ins[27:20]));
    end
    if (kind == K_RD) exp_rdata = rexp;
    chk({tag, " rdata"}, 64'(pio_rdata), 64'(exp_rdata));
    repeat (2) tick();
    chk({tag, " hold en=1"}, 64'(pio_flags), 64'(fl));
    pio_enable = 1'b0;
    repeat (2) tick();
    chk({tag, " hold en=0"}, 64'(pio_flags), 64'(fl));
  endtask

  // rdy/dn: edge (counted from acceptance) at which cmd_ready/cmd_done are
  // sampled high; dn=0 means never. glitch: edge where the strobe is dropped
  // for one clock and raised again while busy (0 = none).
  task automatic do_exec(input logic [28:0] ins, input int rdy, input int dn,
                         input int glitch, input string tag);
    int fin;
    int lat;
    logic [3:0] fl;
    logic exp_v;
    fin = (dn != 0 && dn >= rdy && dn <= int'(T) + 1) ? dn : int'(T) + 1;
    fl  = (fin == dn) ? 4'b0001 : 4'b1101;
    lat = fin + 2;
    strobe(ins);
    chk({tag, " busy"}, 64'(pio_flags), 64'(4'b0010));
    for (int e = 1; e <= lat; e++) begin
      cmd_ready = (e == rdy);
      cmd_done  = (e == dn);
      if (glitch != 0 && e == glitch) pio_enable = 1'b0;
      if (glitch != 0 && e == glitch + 1) begin
        pio_enable   = 1'b1;
        pio_instruct = 29'($urandom);
      end
      tick();
      cmd_ready = 1'b0;
      cmd_done  = 1'b0;
      if (e < lat) begin
        exp_v = (e < rdy) && (e < fin);
        chk({tag, " cmd_valid"}, 64'(cmd_valid), 64'(exp_v));
        if (exp_v) begin
          chk({tag, " cmd_op"}, 64'(cmd_op), 64'(ins[2:0]));
          chk({tag, " cmd_param"}, 64'(cmd_param), 64'(ins[27:20]));
        end
        chk({tag, " busy flags"}, 64'(pio_flags), 64'(4'b0010));
      end
    end
    chk({tag, " flags"}, 64'(pio_flags), 64'(fl));
    chk({tag, " valid low"}, 64'(cmd_valid), 64'(0));
    pio_enable = 1'b0;
    repeat (2) tick();
    chk({tag, " hold en=0"}, 64'(pio_flags), 64'(fl));
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    tick();
    chk({tag, " late done"}, 64'(pio_flags), 64'(fl));
    chk({tag, " op kept"}, 64'(cmd_op), 64'(ins[2:0]));
  endtask

  initial begin
    logic [28:0] ins;
    logic [2:0]  rop;
    logic [16:0] ra;
    int lat;
    int kind;
    logic [3:0] fl;

    reset_reset_n = 1'b0;
    pio_enable    = 1'b0;
    pio_instruct  = '0;
    cmd_ready     = 1'b0;
    cmd_done      = 1'b0;
    wmem[5]       = 8'h3C;
    repeat (3) tick();
    chk("reset outputs", all_out(), 64'(0));
    reset_reset_n = 1'b1;
    tick();
    chk("idle outputs", all_out(), 64'(0));

    do_simple(mk(1'b0, 8'hA5, 17'd100, 3'd1), "wr100");
    do_simple(mk(1'b0, 8'h00, 17'd100, 3'd2), "rd100");
    do_simple(mk(1'b0, 8'h00, 17'd5, 3'd2), "rd5");
    do_simple(mk(1'b0, 8'h00, 17'd76800, 3'd2), "rd_oob");
    do_simple(mk(1'b0, 8'h77, 17'd76800, 3'd1), "wr_oob");
    do_simple(mk(1'b0, 8'h5E, 17'd76799, 3'd1), "wr_last");
    do_simple(mk(1'b0, 8'h00, 17'd76799, 3'd2), "rd_last");
    do_simple(mk(1'b0, 8'h00, 17'd0, 3'd7), "op7");
    do_simple(mk(1'b1, 8'h00, 17'd0, 3'd0), "resv");
    do_simple(mk(1'b0, 8'h00, 17'd0, 3'd0), "nop");

    do_exec(mk(1'b0, 8'h10, 17'd0, 3'd4), 7, 20, 0, "exec4");
    do_exec(mk(1'b0, 8'h22, 17'd9, 3'd3), 3, 3, 0, "exec_same");
    do_exec(mk(1'b0, 8'h33, 17'd0, 3'd5), 2, 0, 6, "timeout");
    do_exec(mk(1'b0, 8'h44, 17'd0, 3'd6), 40, 0, 0, "to_noready");
    do_exec(mk(1'b0, 8'h55, 17'd0, 3'd6), 2, int'(T) + 1, 0, "done_at_limit");

    // Reset while a READ is in flight.
    strobe(mk(1'b0, 8'h00, 17'd5, 3'd2));
    repeat (2) tick();
    chk("rst mem_re in flight", 64'(mem_re), 64'(1));
    reset_reset_n = 1'b0;
    #1;
    chk("rst async outputs", all_out(), 64'(0));
    pio_enable = 1'b0;
    repeat (2) tick();
    chk("rst held outputs", all_out(), 64'(0));
    reset_reset_n = 1'b1;
    tick();
    exp_rdata = 8'h00;
    chk("rst released", all_out(), 64'(0));
    do_simple(mk(1'b0, 8'h00, 17'd5, 3'd2), "rd_after_rst");

    for (int i = 0; i < 24; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = ($urandom_range(0, 3) == 0) ? 17'(int'(DEPTH) + int'($urandom_range(0, 50)))
                                       : 17'($urandom_range(0, int'(DEPTH) - 1));
      if ($urandom_range(0, 5) == 0) ra = 17'($urandom_range(100, 104));
      ins = mk(1'($urandom_range(0, 9) == 0), 8'($urandom), ra, rop);
      model(ins, lat, fl, kind);
      if (kind == K_EX) begin
        do_exec(ins, int'($urandom_range(2, 6)),
                ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(1, int'(T) + 4)),
                0, $sformatf("rnd%0d exec", i));
      end else begin
        do_simple(ins, $sformatf("rnd%0d", i));
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
